// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: accepts tagged ALU commands, drives an attached ALU, waits
// ALU_LAT cycles, captures the result and returns it as a tagged response.
// Ports: clk/rst_n (sync, active-low); cmd_* valid/ready command channel;
// alu_* operands to and result/carry from the ALU; resp_* valid/ready response
// channel; busy, cmd_count (wrapping) and err_count (saturating) status.
module alu_cmd_issuer #(
  parameter int WIDTH   = 32,
  parameter int SHW     = 5,
  parameter int TAGW    = 4,
  parameter int ALU_LAT = 0,
  parameter int CNTW    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [SHW-1:0]   cmd_shift,
  input  logic [TAGW-1:0]  cmd_tag,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_input1,
  output logic [WIDTH-1:0] alu_input2,
  output logic [SHW-1:0]   alu_shift,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_carry,
  output logic             resp_err,
  output logic [TAGW-1:0]  resp_tag,
  output logic             busy,
  output logic [CNTW-1:0]  cmd_count,
  output logic [CNTW-1:0]  err_count
);
  typedef enum logic [1:0] {IDLE, DRIVE, WAIT, RESP} state_t;
  // WAIT runs ALU_LAT-1 extra cycles after DRIVE so the sample lands ALU_LAT cycles after the operands settle
  localparam logic [3:0] LAT_M1 = ALU_LAT > 0 ? 4'(ALU_LAT - 1) : 4'd0;
  state_t           state_q, state_d;
  logic [3:0]       alu_opcode_q, alu_opcode_d, cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_input1_q, alu_input1_d, alu_input2_q, alu_input2_d;
  logic [SHW-1:0]   alu_shift_q, alu_shift_d;
  logic [TAGW-1:0]  tag_q, tag_d, resp_tag_q, resp_tag_d;
  logic [WIDTH-1:0] resp_result_q, resp_result_d;
  logic             resp_carry_q, resp_carry_d, resp_err_q, resp_err_d, sample;
  logic [CNTW-1:0]  cmd_count_q, cmd_count_d, err_count_q, err_count_d;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      alu_opcode_q  <= '0;
      alu_input1_q  <= '0;
      alu_input2_q  <= '0;
      alu_shift_q   <= '0;
      cnt_q         <= '0;
      tag_q         <= '0;
      resp_result_q <= '0;
      resp_carry_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_tag_q    <= '0;
      cmd_count_q   <= '0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      alu_opcode_q  <= alu_opcode_d;
      alu_input1_q  <= alu_input1_d;
      alu_input2_q  <= alu_input2_d;
      alu_shift_q   <= alu_shift_d;
      cnt_q         <= cnt_d;
      tag_q         <= tag_d;
      resp_result_q <= resp_result_d;
      resp_carry_q  <= resp_carry_d;
      resp_err_q    <= resp_err_d;
      resp_tag_q    <= resp_tag_d;
      cmd_count_q   <= cmd_count_d;
      err_count_q   <= err_count_d;
    end
  end
  always_comb begin
    state_d       = state_q;
    alu_opcode_d  = alu_opcode_q;
    alu_input1_d  = alu_input1_q;
    alu_input2_d  = alu_input2_q;
    alu_shift_d   = alu_shift_q;
    cnt_d         = cnt_q;
    tag_d         = tag_q;
    resp_result_d = resp_result_q;
    resp_carry_d  = resp_carry_q;
    resp_err_d    = resp_err_q;
    resp_tag_d    = resp_tag_q;
    cmd_count_d   = cmd_count_q;
    err_count_d   = err_count_q;
    sample        = (state_q == DRIVE && ALU_LAT == 0) || (state_q == WAIT && cnt_q == 4'd0);
    case (state_q)
      IDLE: if (cmd_valid) begin
        cmd_count_d = cmd_count_q + 1'b1;
        tag_d       = cmd_tag;
        if (cmd_opcode < 4'd6) begin
          alu_opcode_d = cmd_opcode;
          alu_input1_d = cmd_a;
          alu_input2_d = cmd_b;
          alu_shift_d  = cmd_shift;
          state_d      = DRIVE;
        end else begin
          // illegal opcode: ALU untouched, error response ready next cycle
          resp_result_d = '0;
          resp_carry_d  = 1'b0;
          resp_err_d    = 1'b1;
          resp_tag_d    = cmd_tag;
          err_count_d   = &err_count_q ? err_count_q : err_count_q + 1'b1;
          state_d       = RESP;
        end
      end
      DRIVE: begin
        cnt_d   = LAT_M1;
        state_d = ALU_LAT == 0 ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == 4'd0 ? RESP : WAIT;
      end
      RESP: state_d = resp_ready ? IDLE : RESP;
    endcase
    if (sample) begin
      resp_result_d = alu_result;
      // carry is only meaningful for ADD; other ops may leave garbage on it
      resp_carry_d  = alu_opcode_q == 4'd4 && alu_carry;
      resp_err_d    = 1'b0;
      resp_tag_d    = tag_q;
    end
  end
  assign cmd_ready   = state_q == IDLE;
  assign resp_valid  = state_q == RESP;
  assign busy        = state_q != IDLE;
  assign alu_opcode  = alu_opcode_q;
  assign alu_input1  = alu_input1_q;
  assign alu_input2  = alu_input2_q;
  assign alu_shift   = alu_shift_q;
  assign resp_result = resp_result_q;
  assign resp_carry  = resp_carry_q;
  assign resp_err    = resp_err_q;
  assign resp_tag    = resp_tag_q;
  assign cmd_count   = cmd_count_q;
  assign err_count   = err_count_q;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: two issuers (ALU_LAT=0/CNTW=16 and ALU_LAT=3/CNTW=4) with behavioural ALUs
module tb_alu_cmd_issuer;
  logic clk = 1'b0, rst_n;
  always #5 clk = ~clk;
  logic        cv[2], cr[2], rv[2], rr[2], rc[2], re[2], bz[2], acar[2];
  logic [3:0]  cop[2], aop[2], ctag[2], rtag[2];
  logic [31:0] ca[2], cb[2], ai1[2], ai2[2], ares[2], rres[2];
  logic [4:0]  csh[2], ash[2];
  logic [15:0] ccnt[2], ecnt[2];
  int pass_n = 0, tot_n = 0;
  function automatic logic [32:0] alu_f(input logic [3:0] op, input logic [31:0] a, b, input logic [4:0] s);
    logic [31:0] r;
    if (op == 4'd4) return {1'b0, a} + {1'b0, b};
    r = op == 4'd0 ? (a << s) | (a >> (32 - int'(s))) :
        op == 4'd1 ? (a >> s) | (a << (32 - int'(s))) :
        op == 4'd2 ? (a > b ? a : b) :
        op == 4'd3 ? (a < b ? a : b) : a * b;
    return {1'b1, r};
  endfunction
  for (genvar g = 0; g < 2; g++) begin : gd
    localparam int CW = g ? 4 : 16;
    logic [CW-1:0] cc, ec;
    logic [32:0] f0, p1, p2, p3;
    alu_cmd_issuer #(.ALU_LAT(g ? 3 : 0), .CNTW(CW)) u (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cv[g]), .cmd_ready(cr[g]), .cmd_opcode(cop[g]),
      .cmd_a(ca[g]), .cmd_b(cb[g]), .cmd_shift(csh[g]), .cmd_tag(ctag[g]),
      .alu_opcode(aop[g]), .alu_input1(ai1[g]), .alu_input2(ai2[g]), .alu_shift(ash[g]),
      .alu_result(ares[g]), .alu_carry(acar[g]), .resp_valid(rv[g]), .resp_ready(rr[g]),
      .resp_result(rres[g]), .resp_carry(rc[g]), .resp_err(re[g]), .resp_tag(rtag[g]),
      .busy(bz[g]), .cmd_count(cc), .err_count(ec));
    assign ccnt[g] = 16'(cc);
    assign ecnt[g] = 16'(ec);
    assign f0 = alu_f(aop[g], ai1[g], ai2[g], ash[g]);
    always @(posedge clk) begin
      p1 <= f0;
      p2 <= p1;
      p3 <= p2;
    end
    assign {acar[g], ares[g]} = g ? p3 : f0;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  task automatic send(input int d, input logic [3:0] op, input logic [31:0] a, b, input logic [4:0] sh, input logic [3:0] tag);
    cv[d] = 1'b1; cop[d] = op; ca[d] = a; cb[d] = b; csh[d] = sh; ctag[d] = tag;
    @(negedge clk);
    cv[d] = 1'b0;
  endtask
  task automatic wait_resp(input int d, output int lat);
    lat = 1;
    while (!rv[d] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask
  typedef struct {logic [3:0] op; logic [31:0] a, b; logic [4:0] sh; logic [3:0] tag; logic [31:0] res; logic car, err;} vec_t;
  vec_t tv[8];
  initial begin
    int lat, idx, last_c, n_acc;
    logic [3:0] last_op;
    logic [3:0] got[$];
    bit ld, ev;
    bit pend[2], accp[2], ecar[2], eerr[2];
    int due[2], mcc[2], mec[2], mask[2];
    logic [31:0] er[2];
    logic [3:0] etag[2];
    logic [32:0] fr;
    tv[0] = '{4'd4, 32'hFFFF_FFFF, 32'h1, 5'd0, 4'd3, 32'h0, 1'b1, 1'b0};
    tv[1] = '{4'd0, 32'h8000_0001, 32'h0, 5'd4, 4'd1, 32'h18, 1'b0, 1'b0};
    tv[2] = '{4'd2, 32'd5, 32'd9, 5'd0, 4'd2, 32'd9, 1'b0, 1'b0};
    tv[3] = '{4'd3, 32'd5, 32'd9, 5'd0, 4'd4, 32'd5, 1'b0, 1'b0};
    tv[4] = '{4'd1, 32'h1, 32'h0, 5'd1, 4'd5, 32'h8000_0000, 1'b0, 1'b0};
    tv[5] = '{4'd5, 32'd7, 32'd6, 5'd0, 4'd6, 32'd42, 1'b0, 1'b0};
    tv[6] = '{4'd4, 32'd1, 32'd2, 5'd0, 4'd7, 32'd3, 1'b0, 1'b0};
    tv[7] = '{4'd9, 32'd11, 32'd12, 5'd3, 4'hA, 32'h0, 1'b0, 1'b1};
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      cv[d] = 0; rr[d] = 0; cop[d] = 0; ca[d] = 0; cb[d] = 0; csh[d] = 0; ctag[d] = 0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", cr[d], 1); chk("rst_valid", rv[d], 0); chk("rst_busy", bz[d], 0);
      chk("rst_cmdcnt", ccnt[d], 0); chk("rst_errcnt", ecnt[d], 0);
      chk("rst_aluop", aop[d], 0); chk("rst_alua", ai1[d], 0); chk("rst_alub", ai2[d], 0); chk("rst_alush", ash[d], 0);
      chk("rst_rres", rres[d], 0); chk("rst_rcar", rc[d], 0); chk("rst_rerr", re[d], 0); chk("rst_rtag", rtag[d], 0);
    end
    rst_n = 1'b1;
    rr[0] = 1'b1;
    last_op = 4'd0;
    for (int i = 0; i < 8; i++) begin
      chk("tbl_ready", cr[0], 1);
      send(0, tv[i].op, tv[i].a, tv[i].b, tv[i].sh, tv[i].tag);
      wait_resp(0, lat);
      chk("tbl_latency", lat, tv[i].err ? 1 : 2);
      chk("tbl_result", rres[0], tv[i].res);
      chk("tbl_carry", rc[0], tv[i].car);
      chk("tbl_err", re[0], tv[i].err);
      chk("tbl_tag", rtag[0], tv[i].tag);
      if (!tv[i].err) last_op = tv[i].op;
      chk("tbl_aluop", aop[0], last_op);
      if (i == 0) chk("tbl_cmdcnt1", ccnt[0], 1);
      @(negedge clk);
      chk("tbl_valid_drop", rv[0], 0);
      chk("tbl_ready_back", cr[0], 1);
    end
    chk("tbl_cmdcnt", ccnt[0], 8);
    chk("tbl_errcnt", ecnt[0], 1);
    idx = 0; ld = 1; n_acc = 0; last_c = 0;
    for (int c = 0; c < 20; c++) begin
      if (ld) begin
        cv[0] = idx < 4; cop[0] = 4'd4; ca[0] = 32'(idx * 3); cb[0] = 32'd100; ctag[0] = 4'(idx + 1);
        ld = 0;
      end
      if (rv[0]) begin
        got.push_back(rtag[0]);
        chk("b2b_result", rres[0], 32'((int'(rtag[0]) - 1) * 3 + 100));
      end
      if (cv[0] && cr[0]) begin
        if (n_acc > 0) chk("b2b_spacing", c - last_c, 3);
        last_c = c; n_acc++; idx++; ld = 1;
      end
      @(negedge clk);
    end
    chk("b2b_accepts", n_acc, 4);
    chk("b2b_resps", got.size(), 4);
    for (int i = 0; i < got.size(); i++) chk("b2b_tag_order", got[i], i + 1);
    rr[1] = 1'b0;
    send(1, 4'd5, 32'd7, 32'd6, 5'd0, 4'd9);
    wait_resp(1, lat);
    chk("lat3_latency", lat, 5);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", rv[1], 1); chk("stall_result", rres[1], 42); chk("stall_tag", rtag[1], 9);
      chk("stall_busy", bz[1], 1); chk("stall_ready", cr[1], 0);
      @(negedge clk);
    end
    chk("stall_valid_end", rv[1], 1);
    rr[1] = 1'b1;
    @(negedge clk);
    chk("stall_release_valid", rv[1], 0); chk("stall_release_ready", cr[1], 1);
    chk("stall_release_busy", bz[1], 0); chk("stall_hold_result", rres[1], 42);
    for (int i = 0; i < 16; i++) begin
      send(1, 4'd9, 32'h1234, 32'h5678, 5'd7, 4'hA);
      wait_resp(1, lat);
      if (i == 0) begin
        chk("ill_latency", lat, 1); chk("ill_err", re[1], 1); chk("ill_result", rres[1], 0);
        chk("ill_tag", rtag[1], 4'hA); chk("ill_errcnt1", ecnt[1], 1);
      end
      if (i == 14) chk("ill_errcnt_max", ecnt[1], 15);
      @(negedge clk);
    end
    chk("ill_errcnt_sat", ecnt[1], 15);
    chk("ill_cmdcnt_wrap", ccnt[1], 1);
    chk("ill_aluop_kept", aop[1], 5);
    chk("ill_alua_kept", ai1[1], 7);
    send(1, 4'd4, 32'd1, 32'd2, 5'd0, 4'd3);
    @(negedge clk);
    chk("midrst_busy", bz[1], 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_ready", cr[1], 1); chk("midrst_busy0", bz[1], 0); chk("midrst_valid", rv[1], 0);
    chk("midrst_aluop", aop[1], 0); chk("midrst_alua", ai1[1], 0);
    chk("midrst_cmdcnt", ccnt[1], 0); chk("midrst_errcnt", ecnt[1], 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_resp", rv[1], 0);
    end
    mask[0] = 16'hFFFF; mask[1] = 15;
    for (int d = 0; d < 2; d++) begin
      pend[d] = 0; accp[d] = 0; mcc[d] = 0; mec[d] = 0; due[d] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        ev = pend[d] && c >= due[d];
        chk("rnd_ready", cr[d], !pend[d]);
        chk("rnd_busy", bz[d], pend[d]);
        chk("rnd_valid", rv[d], ev);
        if (ev) begin
          chk("rnd_result", rres[d], er[d]); chk("rnd_carry", rc[d], ecar[d]);
          chk("rnd_err", re[d], eerr[d]); chk("rnd_tag", rtag[d], etag[d]);
        end
        chk("rnd_cmdcnt", ccnt[d], mcc[d]);
        chk("rnd_errcnt", ecnt[d], mec[d]);
        if (!cv[d] || accp[d]) begin
          cv[d] = $urandom_range(0, 2) != 0; cop[d] = 4'($urandom_range(0, 15));
          ca[d] = $urandom; cb[d] = $urandom; csh[d] = 5'($urandom_range(0, 31)); ctag[d] = 4'($urandom_range(0, 15));
        end
        rr[d] = $urandom_range(0, 3) != 0;
        accp[d] = cv[d] && !pend[d];
        if (ev && rr[d]) pend[d] = 0;
        if (accp[d]) begin
          pend[d] = 1;
          etag[d] = ctag[d];
          mcc[d] = (mcc[d] + 1) & mask[d];
          if (cop[d] < 6) begin
            due[d] = c + 2 + (d ? 3 : 0);
            fr = alu_f(cop[d], ca[d], cb[d], csh[d]);
            er[d] = fr[31:0]; ecar[d] = cop[d] == 4 && fr[32]; eerr[d] = 0;
          end else begin
            due[d] = c + 1;
            er[d] = 0; ecar[d] = 0; eerr[d] = 1;
            mec[d] = mec[d] == mask[d] ? mask[d] : mec[d] + 1;
          end
        end
      end
    end
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Initiator side of the generated-ALU interface. Accepts tagged ALU commands on a valid/ready channel and drives opcode, input1, input2 and shiftValue into an attached combinational or pipelined ALU_* instance.
- Samples result and carryFlag after a fixed latency, then returns a tagged response on a second valid/ready channel.
- Sits between a command producer (sequencer or test driver) and any generated ALU that uses the standard opcode map: ROL=0, ROR=1, MAX=2, MIN=3, ADD=4, MUL=5.

Parameters:
- WIDTH, 32: operand/result width.
- SHW, 5: shift-amount width.
- TAGW, 4: command tag width.
- ALU_LAT, 0: ALU cycles from stable inputs to valid result (0 = combinational). Legal range 0..15.
- CNTW, 16: width of status counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  issuer can accept a command.
- cmd_opcode  in  4  ALU opcode.
- cmd_a  in  WIDTH  operand 1.
- cmd_b  in  WIDTH  operand 2.
- cmd_shift  in  SHW  rotate amount.
- cmd_tag  in  TAGW  command id, echoed in the response.
- alu_opcode  out  4  to ALU opcode.
- alu_input1  out  WIDTH  to ALU input1.
- alu_input2  out  WIDTH  to ALU input2.
- alu_shift  out  SHW  to ALU shiftValue.
- alu_result  in  WIDTH  from ALU result.
- alu_carry  in  1  from ALU carryFlag.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_result  out  WIDTH  captured result.
- resp_carry  out  1  captured carry (ADD only).
- resp_err  out  1  illegal opcode.
- resp_tag  out  TAGW  echoed tag.
- busy  out  1  state != IDLE.
- cmd_count  out  CNTW  accepted commands, wraps.
- err_count  out  CNTW  illegal-opcode commands, saturates at all-ones.

Behaviour:
- Reset: state=IDLE. All alu_* outputs 0. All resp_* outputs 0. resp_valid=0, cmd_ready=1, busy=0, both counters 0. Reset wins over every other event in the same cycle.
- FSM states: IDLE, DRIVE, WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - Accept on cmd_valid&&cmd_ready (cycle T). Register opcode, a, b, shift and tag; cmd_count+=1.
  - Legal opcode (0..5): alu_* outputs take the registered values at T+1; go to DRIVE.
  - Illegal opcode (6..15): alu_* outputs unchanged; resp_err=1, resp_result=0, resp_carry=0; go to RESP (resp_valid=1 at T+1); err_count+=1 (saturating).
- DRIVE: alu_* stable. If ALU_LAT=0, sample alu_result/alu_carry at the end of this cycle and go to RESP. Otherwise load the wait counter with ALU_LAT-1 and go to WAIT.
- WAIT: alu_* held stable. Counter decrements each cycle. When it reads 0, sample and go to RESP.
- Latency, legal op: resp_valid rises at T+2+ALU_LAT.
- Capture rules:
  - resp_result = alu_result.
  - resp_carry = alu_carry only when opcode==4, else 0.
  - resp_err=0; resp_tag = registered tag.
- RESP:
  - resp_valid=1, and all resp_* fields held stable until resp_valid&&resp_ready.
  - On handshake: go to IDLE; resp_valid=0 next cycle. resp_* data keeps its last value.
  - cmd_ready=0 in RESP, so there is no same-cycle accept. Minimum spacing between accepts is 3+ALU_LAT cycles (2 for illegal opcodes with immediate ready).
- cmd_ready=0 in DRIVE, WAIT and RESP. Commands presented then are not accepted, and the producer must hold them.
- alu_* outputs keep their last driven values in IDLE and RESP. They change only on the accept of a legal command.
- cmd_count wraps from all-ones to 0.
- Reset mid-operation (any state): the pending command or response is dropped, with no resp_valid pulse. Everything returns to reset values.

Test Plan:
- ALU_LAT=0; ADD a=0xFFFFFFFF b=0x00000001 tag=3; resp_ready=1 -> resp_valid at T+2, resp_result=0x00000000, resp_carry=1, resp_tag=3, resp_err=0, cmd_count=1.
- ROL a=0x80000001 shift=4 -> resp_result=0x00000018, resp_carry=0 even if alu_carry=1. MAX a=5 b=9 -> 9.
- ALU_LAT=3; MUL a=7 b=6 with resp_ready=0 for 5 cycles -> resp_valid at T+5; resp_result=42 held stable, busy=1, cmd_ready=0 throughout; after ready, back to IDLE next cycle.
- Opcode 9, tag=0xA -> no alu_* change, resp_valid at T+1, resp_err=1, resp_result=0, err_count=1. After err_count is forced to 0xFFFF, another illegal opcode leaves it at 0xFFFF.
- ALU_LAT=3; rst_n=0 during WAIT -> next cycle state IDLE, resp_valid never asserts, alu_*=0, counters=0, cmd_ready=1.
- Back-to-back valid commands with resp_ready=1, ALU_LAT=0 -> accepts exactly every 3 cycles; tags returned in order.
